// File: rtl/set_mode_controller.sv
// set_mode_controller: debounced button FSM that cycles hour/min/sec set modes and issues up/down/clear pulses.
// Define AUTO_REPEAT_EN to enable auto-repeat of a held up/down button.
module set_mode_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int TIMEOUT_CYCLES  = 1000000000,
  parameter int BLINK_HALF      = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_clear,
  output logic [2:0] cursor_pos,
  output logic       up_pulse,
  output logic       down_pulse,
  output logic       clear_pulse,
  output logic       set_active,
  output logic       blink
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_t;
  state_t state, nextState;
  logic [3:0] raw, sync1, sync2, level, levelPrev, press;
  logic [DW-1:0] dbCnt [4];
  logic [TW-1:0] idleCnt;
  logic [BW-1:0] blinkCnt;
  logic modeEv, upEv, downEv, setNow, timeoutHit, entering, doUp, doDown, activity, rptFire;
  logic [2:0] nextCursor;
  assign raw = {btn_clear, btn_down, btn_up, btn_mode};
  assign press = level & ~levelPrev;
  // Bit order everywhere: 0 mode, 1 up, 2 down, 3 clear.
  always_ff @(posedge clk)
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      levelPrev <= '0;
      for (int i = 0; i < 4; i++) dbCnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      levelPrev <= level;
      for (int i = 0; i < 4; i++)
        if (sync2[i] == level[i]) dbCnt[i] <= '0;
        else if (dbCnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          level[i] <= sync2[i];
          dbCnt[i] <= '0;
        end else dbCnt[i] <= dbCnt[i] + 1'b1;
    end
  always_comb begin
    setNow = state != RUN;
    modeEv = press[0];
    upEv = setNow & press[1] & ~press[2] & ~modeEv;
    downEv = setNow & press[2] & ~press[1] & ~modeEv;
    timeoutHit = setNow && idleCnt == TW'(TIMEOUT_CYCLES - 1);
    nextState = modeEv ? (state == SET_SEC ? RUN : state_t'(state + 2'd1)) : timeoutHit ? RUN : state;
    entering = nextState != RUN && nextState != state;
    doUp = (upEv | downEv) ? upEv : rptFire & ~rptDownDir();
    doDown = (upEv | downEv) ? downEv : rptFire & rptDownDir();
    activity = |press | rptFire;
    nextCursor = nextState == SET_HOUR ? 3'b100 : nextState == SET_MIN ? 3'b010 : nextState == SET_SEC ? 3'b001 : 3'b000;
  end
`ifdef AUTO_REPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  logic rptArmed, rptDown, rptFirst, rptHeld, rptHit;
  logic [RW-1:0] rptCnt;
  function automatic logic rptDownDir();
    return rptDown;
  endfunction
  always_comb begin
    rptHeld = rptDown ? level[2] : level[1];
    rptHit = rptCnt == (rptFirst ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1));
    rptFire = rptArmed & rptHeld & setNow & rptHit & ~modeEv;
  end
  always_ff @(posedge clk)
    if (reset) begin
      rptArmed <= 1'b0;
      rptDown <= 1'b0;
      rptFirst <= 1'b0;
      rptCnt <= '0;
    end else if (upEv | downEv) begin
      rptArmed <= 1'b1;
      rptDown <= downEv;
      rptFirst <= 1'b1;
      rptCnt <= '0;
    end else if (!rptHeld || !setNow) begin
      rptArmed <= 1'b0;
      rptCnt <= '0;
    end else if (rptArmed) begin
      rptCnt <= rptHit ? '0 : rptCnt + 1'b1;
      rptFirst <= rptHit ? 1'b0 : rptFirst;
    end
`else
  function automatic logic rptDownDir();
    return 1'b0;
  endfunction
  assign rptFire = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= RUN;
      cursor_pos <= 3'b000;
      set_active <= 1'b0;
      up_pulse <= 1'b0;
      down_pulse <= 1'b0;
      clear_pulse <= 1'b0;
      blink <= 1'b1;
      idleCnt <= '0;
      blinkCnt <= '0;
    end else begin
      state <= nextState;
      cursor_pos <= nextCursor;
      set_active <= nextState != RUN;
      up_pulse <= doUp;
      down_pulse <= doDown;
      clear_pulse <= press[3];
      idleCnt <= (nextState == RUN || entering || activity) ? '0 : idleCnt + 1'b1;
      if (nextState == RUN || entering || doUp || doDown) begin
        blink <= 1'b1;
        blinkCnt <= '0;
      end else if (blinkCnt == BW'(BLINK_HALF - 1)) begin
        blink <= ~blink;
        blinkCnt <= '0;
      end else blinkCnt <= blinkCnt + 1'b1;
    end
endmodule

// File: tb/tb_set_mode_controller.sv
// tb_set_mode_controller: scoreboard bench; expected pulses are queued at stimulus time and matched as the DUT emits them.
module tb_set_mode_controller;
  logic clk = 1'b0;
  logic reset, btn_mode, btn_up, btn_down, btn_clear;
  logic [2:0] cursor_pos;
  logic up_pulse, down_pulse, clear_pulse, set_active, blink;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int r, e;
  typedef struct {int c; logic [2:0] kind;} exp_t;
  exp_t sb[$];
  logic [2:0] curExp [4] = '{3'b100, 3'b010, 3'b001, 3'b000};

  set_mode_controller #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .TIMEOUT_CYCLES(100), .BLINK_HALF(8)
  ) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .btn_clear(btn_clear), .cursor_pos(cursor_pos), .up_pulse(up_pulse), .down_pulse(down_pulse),
    .clear_pulse(clear_pulse), .set_active(set_active), .blink(blink)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitCyc(int t);
    while (cyc < t) tick(1);
  endtask

  task automatic pushExp(int c, logic [2:0] kind);
    sb.push_back('{c, kind});
  endtask

  task automatic pressMode();
    btn_mode = 1'b1;
    tick(10);
    btn_mode = 1'b0;
    tick(10);
  endtask

  // kind encoding: 1 up, 2 down, 4 clear
  always @(negedge clk)
    if (!reset && (up_pulse || down_pulse || clear_pulse)) begin
      if (sb.size() == 0) check("extra_pulse", int'({clear_pulse, down_pulse, up_pulse}), 0);
      else begin
        exp_t x;
        x = sb.pop_front();
        check("pulse_kind", int'({clear_pulse, down_pulse, up_pulse}), int'(x.kind));
        check("pulse_cycle", cyc, x.c);
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    {btn_mode, btn_up, btn_down, btn_clear} = 4'b0;
    tick(3);
    check("rst_cursor", int'(cursor_pos), 0);
    check("rst_set", int'(set_active), 0);
    check("rst_blink", int'(blink), 1);
    check("rst_pulses", int'({clear_pulse, down_pulse, up_pulse}), 0);
    reset = 1'b0;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      pressMode();
      check("mode_cursor", int'(cursor_pos), int'(curExp[i]));
      check("mode_set", int'(set_active), i < 3 ? 1 : 0);
    end
    r = cyc;
    pushExp(r + 7, 3'b100);
    btn_clear = 1'b1;
    tick(10);
    btn_clear = 1'b0;
    tick(10);
    check("clear_cursor", int'(cursor_pos), 0);
    btn_up = 1'b1;
    tick(10);
    btn_up = 1'b0;
    tick(10);
    pressMode();
    pressMode();
    check("min_cursor", int'(cursor_pos), 3'b010);
    btn_up = 1'b1;
    tick(3);
    btn_up = 1'b0;
    tick(10);
    r = cyc;
    pushExp(r + 7, 3'b001);
    btn_up = 1'b1;
    tick(10);
    btn_up = 1'b0;
    tick(10);
    r = cyc;
    pushExp(r + 7, 3'b010);
    btn_down = 1'b1;
    tick(10);
    btn_down = 1'b0;
    tick(10);
    btn_up = 1'b1;
    btn_down = 1'b1;
    tick(10);
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick(10);
    check("updown_cursor", int'(cursor_pos), 3'b010);
    r = cyc;
    e = r + 7;
    btn_mode = 1'b1;
    btn_up = 1'b1;
    tick(10);
    btn_mode = 1'b0;
    btn_up = 1'b0;
    waitCyc(e + 4);
    check("sec_cursor", int'(cursor_pos), 3'b001);
    check("sec_blink_a", int'(blink), 1);
    waitCyc(e + 12);
    check("sec_blink_b", int'(blink), 0);
    waitCyc(e + 20);
    check("sec_blink_c", int'(blink), 1);
    waitCyc(e + 99);
    check("pre_timeout", int'(set_active), 1);
    waitCyc(e + 100);
    check("timeout_set", int'(set_active), 0);
    check("timeout_cursor", int'(cursor_pos), 0);
    check("timeout_blink", int'(blink), 1);
    pressMode();
    r = cyc;
    pushExp(r + 7, 3'b001);
`ifdef AUTO_REPEAT_EN
    for (int t = r + 27; t <= r + 66; t += 5) pushExp(t, 3'b001);
`endif
    btn_up = 1'b1;
    waitCyc(r + 11);
    check("blink_restart", int'(blink), 1);
    waitCyc(r + 15);
    check("blink_after", int'(blink), 0);
    waitCyc(r + 60);
    btn_up = 1'b0;
    tick(10);
    pressMode();
    pressMode();
    pressMode();
    check("back_to_run", int'(cursor_pos), 0);
    pressMode();
    check("hour_again", int'(cursor_pos), 3'b100);
    btn_up = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(2);
    check("rst_mid_cursor", int'(cursor_pos), 0);
    check("rst_mid_set", int'(set_active), 0);
    reset = 1'b0;
    tick(15);
    btn_up = 1'b0;
    tick(10);
    check("rst_after_cursor", int'(cursor_pos), 0);
    tick(20);
    check("sb_leftover", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/set_mode_controller.md
SET_MODE_CONTROLLER -- requirements
Module: set_mode_controller

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, the number of consecutive stable cycles before a button level is accepted.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 50000000, the cycles from the first up/down pulse to the first auto-repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 10000000, the cycles between auto-repeat pulses.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000000, the inactivity cycles in a set state before returning to RUN.
REQ-005 The block SHALL have parameter BLINK_HALF, default 25000000, the blink half-period in cycles.
REQ-006 The block SHALL have ports as listed: clk  in  1  system clock, 100 MHz; reset  in  1  synchronous, active-high.
REQ-007 The block SHALL have inputs btn_mode, btn_up, btn_down, btn_clear, each  in  1  raw asynchronous active-high button.
REQ-008 The block SHALL have output cursor_pos  out  3  one-hot field select: 100 hour, 010 minute, 001 second, 000 none.
REQ-009 The block SHALL have outputs up_pulse, down_pulse, clear_pulse, each  out  1  single-cycle command to the time storage.
REQ-010 The block SHALL have outputs set_active  out  1  high in any set state; blink  out  1  display enable for the selected field.

Function
REQ-011 Each raw button SHALL pass through a 2-flop synchronizer, then a debouncer whose accepted level changes only after DEBOUNCE_CYCLES consecutive cycles at the new synchronized value.
REQ-012 A press event SHALL be a debounced 0->1 edge; the first resulting pulse SHALL assert exactly DEBOUNCE_CYCLES+3 cycles after the raw input rises and stays high.
REQ-013 The FSM SHALL have states RUN (cursor 000), SET_HOUR (100), SET_MIN (010) and SET_SEC (001); a mode press SHALL advance RUN->SET_HOUR->SET_MIN->SET_SEC->RUN.
REQ-014 up_pulse/down_pulse SHALL be emitted only in set states; presses in RUN SHALL be ignored.
REQ-015 Simultaneous up and down press events SHALL both be suppressed.
REQ-016 A mode press in the same cycle as an up/down press SHALL win; the up/down press SHALL be discarded.
REQ-017 A clear press SHALL emit clear_pulse in any state and SHALL NOT change FSM state.
REQ-018 An inactivity counter SHALL reset on every press event and on entering a set state; reaching TIMEOUT_CYCLES in a set state SHALL force RUN.
REQ-019 blink SHALL be 1 in RUN; in set states it SHALL toggle every BLINK_HALF cycles, restarting high on state entry and on every up/down pulse.
REQ-020 All pulse outputs SHALL be exactly one cycle wide; at most one of up_pulse and down_pulse SHALL be high in any cycle.

Reset
REQ-021 While reset is high, the block SHALL force: state RUN, cursor_pos 000, all pulses 0, set_active 0, blink 1, and all counters 0.
REQ-022 While reset is high, the block SHALL force all debounced levels to 0.
REQ-023 A button held through the release of reset SHALL produce a press event after DEBOUNCE_CYCLES; a reset asserted mid-repeat or mid-debounce SHALL abort it with no pulse.

Configuration
REQ-024 With macro AUTO_REPEAT_EN defined, an up/down button still held REPEAT_DELAY cycles after its first pulse SHALL repeat the pulse every REPEAT_PERIOD cycles while held and in a set state, each repeat counting as activity.
REQ-025 Without AUTO_REPEAT_EN, holding a button SHALL produce exactly one pulse and the repeat counters SHALL be absent.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, TIMEOUT_CYCLES=100, BLINK_HALF=8)
REQ-026 Mode pressed 4 times, 10 cycles each -> cursor_pos 100, 010, 001, 000; set_active 1,1,1,0.
REQ-027 btn_up glitch high 3 cycles in SET_MIN -> no up_pulse; held 10 cycles -> one up_pulse, 7 cycles after the rise.
REQ-028 In SET_HOUR, hold btn_up 60 cycles with AUTO_REPEAT_EN -> pulses at first+0, +20, +25, +30, ...; without the macro -> exactly one pulse.
REQ-029 Enter SET_SEC with no further presses -> RUN exactly 100 cycles after entry; blink toggles every 8 cycles, then holds 1.
REQ-030 btn_up and btn_down rise together in SET_MIN -> neither pulse; btn_clear in RUN -> one clear_pulse with cursor_pos kept at 000.
REQ-031 Reset asserted 3 cycles into a held btn_up in SET_HOUR -> RUN, no pulse; button held after reset release -> no pulse because the state is RUN.
